timer_unit: RTL and testbench

- Millisecond countdown timer that implements the far end of the register-file timer interface.
- Consumes the time, start and interrupt-enable values driven from the timer registers, and returns the done flag read back through the read-only done register.
- Raises a one-cycle interrupt request toward the interrupt controller, which feeds interrupt_status.
- A software write sequence (load time, set start, poll done or take interrupt, clear start) fully controls it.

---
 rtl/timer_unit_pkg.sv | 16 +
 rtl/timer_unit_ms_prescaler.sv | 48 ++++
 rtl/timer_unit.sv | 136 +++++++++++++
 tb/tb_timer_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/timer_unit_pkg.sv
// timer_unit_pkg: definitions shared by the millisecond timer slice.
//   state_e            - timer FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   TIMER_TIME_W       - default width of the millisecond count
//   TIMER_TICKS_PER_MS - default clk cycles per millisecond
package timer_unit_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int unsigned TIMER_TIME_W       = 16;
   localparam int unsigned TIMER_TICKS_PER_MS = 27000;

endpackage : timer_unit_pkg

// File: rtl/timer_unit_ms_prescaler.sv
// ms_prescaler: divides clk down to a one-cycle millisecond tick.
//   clk    in  system clock
//   rst    in  synchronous active-high reset
//   clear  in  restart the count from 0 (asserted on entry to RUN)
//   enable in  count this cycle
//   tick   out one-cycle pulse every TICKS_PER_MS enabled cycles
module ms_prescaler #(
   parameter int unsigned TICKS_PER_MS = 27000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int unsigned CNT_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICKS_PER_MS - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Tick fires on the last enabled cycle of each period, so the owner sees
   // it in the same cycle the counter wraps.
   assign tick = enable && (cnt_q == CNT_MAX);

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule : ms_prescaler

// File: rtl/timer_unit.sv
// timer_unit: millisecond countdown timer behind the register-file timer
// interface.
//   clk              in  system clock
//   rst              in  synchronous active-high reset
//   time_ms          in  countdown length in ms, sampled on a start rising edge
//   start            in  level start/arm from the start register
//   interrupt_enable in  sampled in the expiry cycle to decide irq
//   done             out expiry flag, held until start is dropped
//   irq              out one-cycle interrupt request at expiry
//   busy             out high while counting
//   remaining_ms     out live remaining milliseconds
module timer_unit
   import timer_unit_pkg::*;
#(
   parameter int unsigned TICKS_PER_MS = TIMER_TICKS_PER_MS,
   parameter int unsigned TIME_W       = TIMER_TIME_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [TIME_W-1:0] time_ms,
   input  logic              start,
   input  logic              interrupt_enable,
   output logic              done,
   output logic              irq,
   output logic              busy,
   output logic [TIME_W-1:0] remaining_ms
);

   state_e            state_q, state_d;
   logic              start_q, start_d;
   logic              done_q, done_d;
   logic              irq_q, irq_d;
   logic              busy_q, busy_d;
   logic [TIME_W-1:0] rem_q, rem_d;

   logic start_rise;
   logic presc_clear;
   logic presc_en;
   logic ms_tick;

   assign start_rise = start && !start_q;
   assign start_d    = start;

   ms_prescaler #(
      .TICKS_PER_MS (TICKS_PER_MS)
   ) u_prescaler (
      .clk    (clk),
      .rst    (rst),
      .clear  (presc_clear),
      .enable (presc_en),
      .tick   (ms_tick)
   );

   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      done_d      = done_q;
      busy_d      = busy_q;
      irq_d       = 1'b0;
      presc_clear = 1'b0;
      presc_en    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start_rise) begin
               if (time_ms != '0) begin
                  state_d     = ST_RUN;
                  rem_d       = time_ms;
                  busy_d      = 1'b1;
                  presc_clear = 1'b1;
               end else begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  irq_d   = interrupt_enable;
               end
            end
         end

         ST_RUN: begin
            // Dropping start aborts; remaining_ms keeps its last value.
            if (!start) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end else begin
               presc_en = 1'b1;
               if (ms_tick) begin
                  if (rem_q == TIME_W'(1)) begin
                     state_d = ST_DONE;
                     rem_d   = '0;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                     irq_d   = interrupt_enable;
                  end else begin
                     rem_d = rem_q - TIME_W'(1);
                  end
               end
            end
         end

         ST_DONE: begin
            if (!start) begin
               state_d = ST_IDLE;
               done_d  = 1'b0;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         start_q <= 1'b0;
         done_q  <= 1'b0;
         irq_q   <= 1'b0;
         busy_q  <= 1'b0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         start_q <= start_d;
         done_q  <= done_d;
         irq_q   <= irq_d;
         busy_q  <= busy_d;
         rem_q   <= rem_d;
      end
   end

   assign done         = done_q;
   assign irq          = irq_q;
   assign busy         = busy_q;
   assign remaining_ms = rem_q;

endmodule : timer_unit

// File: tb/tb_timer_unit.sv
// tb_timer_unit: directed self-checking bench for timer_unit with
// TICKS_PER_MS=4. Inputs change and outputs are sampled 1 time unit after
// each rising clock edge.
module tb_timer_unit;

   logic        clk;
   logic        rst;
   logic [15:0] time_ms;
   logic        start;
   logic        interrupt_enable;
   logic        done;
   logic        irq;
   logic        busy;
   logic [15:0] remaining_ms;

   int unsigned n_cmp;
   int unsigned n_mis;

   timer_unit #(
      .TICKS_PER_MS (4),
      .TIME_W       (16)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .time_ms          (time_ms),
      .start            (start),
      .interrupt_enable (interrupt_enable),
      .done             (done),
      .irq              (irq),
      .busy             (busy),
      .remaining_ms     (remaining_ms)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic d, input logic i,
                          input logic b, input logic [15:0] r);
      chk({tag, ".done"}, {31'd0, done}, {31'd0, d});
      chk({tag, ".irq"},  {31'd0, irq},  {31'd0, i});
      chk({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
      chk({tag, ".rem"},  {16'd0, remaining_ms}, {16'd0, r});
   endtask

   initial begin
      n_cmp            = 0;
      n_mis            = 0;
      rst              = 1'b1;
      start            = 1'b0;
      time_ms          = '0;
      interrupt_enable = 1'b0;

      // Reset state
      step();
      step();
      chk_all("reset", 1'b0, 1'b0, 1'b0, 16'd0);
      rst = 1'b0;
      step();
      chk_all("idle", 1'b0, 1'b0, 1'b0, 16'd0);

      // Basic expiry: 3 ms -> done 12 cycles after RUN entry
      time_ms          = 16'd3;
      interrupt_enable = 1'b1;
      start            = 1'b1;
      step();
      chk_all("basic.run0", 1'b0, 1'b0, 1'b1, 16'd3);
      for (int c = 1; c < 12; c++) begin
         step();
         chk_all("basic.count", 1'b0, 1'b0, 1'b1, 16'(3 - c / 4));
      end
      step();
      chk_all("basic.expire", 1'b1, 1'b1, 1'b0, 16'd0);
      step();
      chk_all("basic.hold", 1'b1, 1'b0, 1'b0, 16'd0);
      step();
      chk_all("basic.hold2", 1'b1, 1'b0, 1'b0, 16'd0);

      // Acknowledge, then 1 ms restart
      start = 1'b0;
      step();
      chk_all("ack", 1'b0, 1'b0, 1'b0, 16'd0);
      time_ms = 16'd1;
      start   = 1'b1;
      step();
      chk_all("ack.run0", 1'b0, 1'b0, 1'b1, 16'd1);
      for (int c = 1; c < 4; c++) begin
         step();
         chk_all("ack.count", 1'b0, 1'b0, 1'b1, 16'd1);
      end
      step();
      chk_all("ack.expire", 1'b1, 1'b1, 1'b0, 16'd0);
      start = 1'b0;
      step();
      chk_all("ack.clear", 1'b0, 1'b0, 1'b0, 16'd0);

      // Zero length with interrupt disabled
      time_ms          = 16'd0;
      interrupt_enable = 1'b0;
      start            = 1'b1;
      step();
      chk_all("zero.done", 1'b1, 1'b0, 1'b0, 16'd0);
      for (int c = 0; c < 3; c++) begin
         step();
         chk_all("zero.hold", 1'b1, 1'b0, 1'b0, 16'd0);
      end
      start = 1'b0;
      step();
      chk_all("zero.ack", 1'b0, 1'b0, 1'b0, 16'd0);

      // Abort: start high for 7 sampled edges of a 5 ms run
      time_ms          = 16'd5;
      interrupt_enable = 1'b1;
      start            = 1'b1;
      step();
      chk_all("abort.run0", 1'b0, 1'b0, 1'b1, 16'd5);
      for (int c = 1; c < 7; c++) begin
         step();
         chk_all("abort.count", 1'b0, 1'b0, 1'b1, 16'(5 - c / 4));
      end
      start = 1'b0;
      step();
      chk_all("abort.stop", 1'b0, 1'b0, 1'b0, 16'd4);
      for (int c = 0; c < 40; c++) begin
         step();
         chk_all("abort.frozen", 1'b0, 1'b0, 1'b0, 16'd4);
      end

      // Mid-run time_ms / interrupt_enable changes
      time_ms          = 16'd2;
      interrupt_enable = 1'b1;
      start            = 1'b1;
      step();
      chk_all("mid.run0", 1'b0, 1'b0, 1'b1, 16'd2);
      time_ms = 16'd9;
      step();
      chk_all("mid.run1", 1'b0, 1'b0, 1'b1, 16'd2);
      interrupt_enable = 1'b0;
      for (int c = 2; c < 8; c++) begin
         step();
         chk_all("mid.count", 1'b0, 1'b0, 1'b1, 16'(2 - c / 4));
      end
      step();
      chk_all("mid.expire", 1'b1, 1'b0, 1'b0, 16'd0);
      start = 1'b0;
      step();
      chk_all("mid.ack", 1'b0, 1'b0, 1'b0, 16'd0);

      // Reset mid-run with start held high
      time_ms          = 16'd10;
      interrupt_enable = 1'b1;
      start            = 1'b1;
      step();
      chk_all("rstmid.run0", 1'b0, 1'b0, 1'b1, 16'd10);
      for (int c = 1; c <= 5; c++) begin
         step();
         chk_all("rstmid.count", 1'b0, 1'b0, 1'b1, 16'(10 - c / 4));
      end
      rst = 1'b1;
      step();
      chk_all("rstmid.reset", 1'b0, 1'b0, 1'b0, 16'd0);
      rst = 1'b0;
      step();
      chk_all("rstmid.rerun0", 1'b0, 1'b0, 1'b1, 16'd10);
      for (int c = 1; c < 40; c++) begin
         step();
         chk_all("rstmid.recount", 1'b0, 1'b0, 1'b1, 16'(10 - c / 4));
      end
      step();
      chk_all("rstmid.expire", 1'b1, 1'b1, 1'b0, 16'd0);
      step();
      chk_all("rstmid.hold", 1'b1, 1'b0, 1'b0, 16'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule : tb_timer_unit
